// File: rtl/branch_predictor.sv
// branch_predictor
//   Bimodal branch predictor: 16-entry table of 2-bit saturating counters
//   indexed by PC[5:2], plus EX-stage misprediction detection, redirect PC
//   generation and saturating statistics counters.
// Ports
//   clk_i            pipeline clock, all state updates on rising edge
//   rst_i            synchronous active-high reset
//   ID_pc_i          PC of the instruction in ID
//   ID_branch_i      ID instruction is a conditional branch
//   predict_o        taken prediction for the ID instruction
//   EX_branch_i      EX instruction is a valid branch
//   EX_predict_i     prediction carried with the EX branch
//   EX_taken_i       actual outcome resolved in EX
//   EX_pc_i          PC of the EX branch
//   EX_branch_pc_i   target address of the EX branch
//   mispredict_o     EX branch prediction was wrong
//   flush_o          IF/ID and ID/EX flush (same as mispredict_o)
//   redirect_pc_o    corrected fetch PC
//   branch_cnt_o     saturating count of resolved branches
//   mispredict_cnt_o saturating count of mispredictions
module branch_predictor (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ID_pc_i,
  input  logic        ID_branch_i,
  output logic        predict_o,
  input  logic        EX_branch_i,
  input  logic        EX_predict_i,
  input  logic        EX_taken_i,
  input  logic [31:0] EX_pc_i,
  input  logic [31:0] EX_branch_pc_i,
  output logic        mispredict_o,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic [15:0] branch_cnt_o,
  output logic [15:0] mispredict_cnt_o
);

  logic [1:0]  pht_q [16];
  logic [15:0] branch_cnt_q;
  logic [15:0] mispredict_cnt_q;
  logic [3:0]  id_idx;
  logic [3:0]  ex_idx;
  logic        mispredict;

  // Only PC[5:2] selects a table entry; the remaining bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{ID_pc_i[31:6], ID_pc_i[1:0], EX_pc_i[1:0]};

  assign id_idx = ID_pc_i[5:2];
  assign ex_idx = EX_pc_i[5:2];

  // Reads the registered table: a same-cycle EX update to the same entry is not bypassed.
  assign predict_o = ID_branch_i & pht_q[id_idx][1];

  assign mispredict    = EX_branch_i & (EX_predict_i ^ EX_taken_i);
  assign mispredict_o  = mispredict;
  assign flush_o       = mispredict;
  assign redirect_pc_o = EX_taken_i ? EX_branch_pc_i : EX_pc_i + 32'd4;

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 16; i++) begin
        pht_q[i] <= 2'b10;
      end
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (EX_branch_i) begin
      if (EX_taken_i) begin
        if (pht_q[ex_idx] != 2'b11) pht_q[ex_idx] <= pht_q[ex_idx] + 2'd1;
      end else begin
        if (pht_q[ex_idx] != 2'b00) pht_q[ex_idx] <= pht_q[ex_idx] - 2'd1;
      end
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 16'd1;
      if (mispredict && (mispredict_cnt_q != '1)) mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Scoreboard bench: the stimulus process computes the expected response of
//   each cycle from a behavioural model and queues it; a monitor process pops
//   and compares on the falling edge.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] ID_pc_i = '0;
  logic        ID_branch_i = 1'b0;
  logic        predict_o;
  logic        EX_branch_i = 1'b0;
  logic        EX_predict_i = 1'b0;
  logic        EX_taken_i = 1'b0;
  logic [31:0] EX_pc_i = '0;
  logic [31:0] EX_branch_pc_i = '0;
  logic        mispredict_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] branch_cnt_o;
  logic [15:0] mispredict_cnt_o;

  branch_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_pc_i(ID_pc_i), .ID_branch_i(ID_branch_i), .predict_o(predict_o),
    .EX_branch_i(EX_branch_i), .EX_predict_i(EX_predict_i), .EX_taken_i(EX_taken_i),
    .EX_pc_i(EX_pc_i), .EX_branch_pc_i(EX_branch_pc_i),
    .mispredict_o(mispredict_o), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic        predict;
    logic        mispredict;
    logic [31:0] redirect;
    logic [15:0] bcnt;
    logic [15:0] mcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: counter strength per table slot plus statistics.
  int   m_tbl [16];
  int   m_bcnt;
  int   m_mcnt;

  function automatic int sat_inc(int v, int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  function automatic int sat_dec(int v);
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = 2;
    m_bcnt = 0;
    m_mcnt = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: outputs are settled mid-cycle.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".predict"}, {31'd0, predict_o}, {31'd0, e.predict});
      chk({e.tag, ".mispredict"}, {31'd0, mispredict_o}, {31'd0, e.mispredict});
      chk({e.tag, ".flush"}, {31'd0, flush_o}, {31'd0, e.mispredict});
      if (e.mispredict) chk({e.tag, ".redirect"}, redirect_pc_o, e.redirect);
      chk({e.tag, ".branch_cnt"}, {16'd0, branch_cnt_o}, {16'd0, e.bcnt});
      chk({e.tag, ".mispredict_cnt"}, {16'd0, mispredict_cnt_o}, {16'd0, e.mcnt});
    end
  end

  // One cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step(input string tag, input logic rst, input logic [31:0] id_pc,
                      input logic id_br, input logic ex_br, input logic ex_pred,
                      input logic ex_tk, input logic [31:0] ex_pc, input logic [31:0] ex_tgt);
    exp_t e;
    int   idx;
    bit   mis;
    rst_i = rst; ID_pc_i = id_pc; ID_branch_i = id_br;
    EX_branch_i = ex_br; EX_predict_i = ex_pred; EX_taken_i = ex_tk;
    EX_pc_i = ex_pc; EX_branch_pc_i = ex_tgt;
    mis          = ex_br && (ex_pred != ex_tk);
    e.tag        = tag;
    e.predict    = id_br && (m_tbl[(id_pc / 4) % 16] >= 2);
    e.mispredict = mis;
    e.redirect   = ex_tk ? ex_tgt : 32'(ex_pc + 64'd4);
    e.bcnt       = 16'(m_bcnt);
    e.mcnt       = 16'(m_mcnt);
    exp_q.push_back(e);
    @(posedge clk_i);
    if (rst) begin
      model_reset();
    end else if (ex_br) begin
      idx = (ex_pc / 4) % 16;
      m_tbl[idx] = ex_tk ? sat_inc(m_tbl[idx], 3) : sat_dec(m_tbl[idx]);
      m_bcnt = sat_inc(m_bcnt, 65535);
      if (mis) m_mcnt = sat_inc(m_mcnt, 65535);
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Read back every table slot through predict_o.
  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) step(tag, 1'b0, 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] rpc;
    logic        rtk;
    logic        rpr;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();

    step("reset_predict", 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sweep("reset_sweep");

    step("nt_upd1", 1'b0, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h80);
    step("nt_upd2", 1'b0, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h80);
    step("nt_upd3", 1'b0, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h80);
    step("nt_after", 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    step("mis_taken", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 32'h40);
    step("mis_wrap", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h100);

    step("coll_prep", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    step("collide", 1'b0, 32'h24, 1'b1, 1'b1, 1'b0, 1'b1, 32'h24, 32'h0);
    step("coll_next", 1'b0, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 10; i++)
      step("no_branch", 1'b0, 32'h24, 1'b1, 1'b0, 1'b1, 1'b1, 32'(i * 4), 32'h40);
    sweep("hold_sweep");

    for (int i = 0; i < 400; i++) begin
      rpc = {$urandom_range(0, 63), 2'b00};
      rtk = 1'($urandom);
      rpr = 1'($urandom);
      step("random", 1'b0, {$urandom_range(0, 63), 2'b00}, 1'($urandom),
           1'($urandom_range(0, 3) != 0), rpr, rtk, rpc, $urandom);
    end
    sweep("random_sweep");

    step("rst_with_upd", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    step("post_rst", 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sweep("post_rst_sweep");

    for (int i = 0; i < 65540; i++)
      step("saturate", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0);
    idle("sat_final");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_i);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
